// File: rtl/tenge_arb_pkg.sv
// Shared types and widths for the 10G MAC TX packet arbiter and its round-robin picker.
package tenge_arb_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    localparam int AXIS_DW = 64;
    localparam int AXIS_KW = 8;
    localparam int CNT_W   = 32;

endpackage

// File: rtl/tenge_rr_pick.sv
// Combinational rotate-priority encoder: first set request after 'last', searching cyclically.
module tenge_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int cand_s;

    // Walk from the farthest offset to the nearest so the nearest set request overwrites the rest.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        cand_s = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = (int'(last) + k) % NUM_REQ;
            valid  = valid | req[cand_s];
            idx    = req[cand_s] ? IDX_W'(cand_s) : idx;
        end
    end

endmodule

// File: rtl/tenge_tx_arb.sv
// Packet-level round-robin arbiter feeding one 10G MAC TX AXI-Stream port; frames never interleave.
// Optional per-requester completed-frame counters are built when TENGE_TXARB_CNT_EN is defined.
module tenge_tx_arb
    import tenge_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       tx_axis_fifo_aclk,
    input  logic                       reset,
    input  logic [NUM_REQ*AXIS_DW-1:0] s_tdata,
    input  logic [NUM_REQ*AXIS_KW-1:0] s_tkeep,
    input  logic [NUM_REQ-1:0]         s_tvalid,
    input  logic [NUM_REQ-1:0]         s_tlast,
    output logic [NUM_REQ-1:0]         s_tready,
    output logic [AXIS_DW-1:0]         m_tdata,
    output logic [AXIS_KW-1:0]         m_tkeep,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_idx,
    input  logic                       CntClr,
    output logic [NUM_REQ*CNT_W-1:0]   FrmCnt
);

    arb_state_t       state_r, state_s;
    logic [IDX_W-1:0] grant_r, grant_s;
    logic [IDX_W-1:0] last_r, last_s;
    logic             pick_valid_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             done_s;

    tenge_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (s_tvalid),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // State, grant and round-robin pointer; pointer resets to the top so requester 0 wins first.
    always_ff @(posedge tx_axis_fifo_aclk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= '0;
            last_r  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
        end
    end

    // Next-state decode plus the zero-latency grant mux (no data register on the path).
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        last_s   = last_r;
        s_tready = '0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s = XFER;
                    grant_s = pick_idx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                m_tdata            = s_tdata[int'(grant_r)*AXIS_DW +: AXIS_DW];
                m_tkeep            = s_tkeep[int'(grant_r)*AXIS_KW +: AXIS_KW];
                m_tvalid           = s_tvalid[grant_r];
                m_tlast            = s_tlast[grant_r];
                s_tready[grant_r]  = m_tready;
                done_s             = m_tvalid & m_tready & m_tlast;
                if (done_s) begin
                    state_s = IDLE;
                    last_s  = grant_r;
                end else begin
                    state_s = XFER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign busy      = (state_r == XFER);
    assign grant_idx = grant_r;

`ifdef TENGE_TXARB_CNT_EN
    logic [CNT_W-1:0] frm_cnt_r [NUM_REQ];

    // Completed-frame counters; a clear beats an increment landing on the same edge.
    always_ff @(posedge tx_axis_fifo_aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                frm_cnt_r[i] <= '0;
            end
        end else if (CntClr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                frm_cnt_r[i] <= '0;
            end
        end else if (done_s) begin
            frm_cnt_r[grant_r] <= frm_cnt_r[grant_r] + CNT_W'(1);
        end else begin
            frm_cnt_r[grant_r] <= frm_cnt_r[grant_r];
        end
    end

    // Flatten the counter array onto the output bus.
    always_comb begin
        FrmCnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            FrmCnt[i*CNT_W +: CNT_W] = frm_cnt_r[i];
        end
    end
`else
    logic cnt_clr_unused_s;

    assign cnt_clr_unused_s = CntClr;
    assign FrmCnt           = '0;
`endif

endmodule

// File: tb/tb_tenge_tx_arb.sv
// Scoreboard bench for tenge_tx_arb: per-requester source models, expected-beat queue, directed timing checks.
module tb_tenge_tx_arb;

    localparam int N     = 4;
    localparam int DEPTH = 64;
`ifdef TENGE_TXARB_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int    req;
        beat_t b;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*64-1:0] s_tdata;
    logic [N*8-1:0]  s_tkeep;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic            busy;
    logic [1:0]      grant_idx;
    logic            CntClr;
    logic [N*32-1:0] FrmCnt;

    beat_t        mem [N][DEPTH];
    int           wr_p [N] = '{default: 0};
    int           rd_p [N] = '{default: 0};
    logic [N-1:0] gap = '0;
    exp_t         exp_q [$];
    int           n_checks = 0;
    int           n_errors = 0;

    tenge_tx_arb #(.NUM_REQ(N)) dut (
        .tx_axis_fifo_aclk (clk),
        .reset             (reset),
        .s_tdata           (s_tdata),
        .s_tkeep           (s_tkeep),
        .s_tvalid          (s_tvalid),
        .s_tlast           (s_tlast),
        .s_tready          (s_tready),
        .m_tdata           (m_tdata),
        .m_tkeep           (m_tkeep),
        .m_tvalid          (m_tvalid),
        .m_tlast           (m_tlast),
        .m_tready          (m_tready),
        .busy              (busy),
        .grant_idx         (grant_idx),
        .CntClr            (CntClr),
        .FrmCnt            (FrmCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic beat_t mk(input int r, input int tag, input int b, input int n);
        beat_t x;
        x.data = {8'hA5, 8'(r), 16'(tag), 32'(b)};
        x.keep = (b == n - 1) ? 8'h0F : 8'hFF;
        x.last = (b == n - 1);
        return x;
    endfunction

    // Queue an n-beat frame at requester r; the first n_exp beats are expected at the MAC side.
    task automatic load_frame(input int r, input int tag, input int n, input int n_exp);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt = mk(r, tag, b, n);
            mem[r][wr_p[r]] = bt;
            wr_p[r]++;
            if (b < n_exp) exp_q.push_back('{req: r, b: bt});
        end
    endtask

    task automatic flush_sources();
        for (int r = 0; r < N; r++) rd_p[r] = wr_p[r];
        exp_q.delete();
        gap = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        tick();
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_budget", 64'(n < 300), 64'd1);
    endtask

    // Source models: advance on an accepted beat, then present the next queued beat.
    initial begin
        logic [N-1:0] hs;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && rd_p[i] < wr_p[i]) rd_p[i]++;
                if (rd_p[i] < wr_p[i] && !gap[i]) begin
                    s_tvalid[i]        = 1'b1;
                    s_tdata[i*64 +: 64] = mem[i][rd_p[i]].data;
                    s_tkeep[i*8 +: 8]   = mem[i][rd_p[i]].keep;
                    s_tlast[i]         = mem[i][rd_p[i]].last;
                end else begin
                    s_tvalid[i]        = 1'b0;
                    s_tdata[i*64 +: 64] = '0;
                    s_tkeep[i*8 +: 8]   = '0;
                    s_tlast[i]         = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted MAC beat is matched against the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                chk("tready_rule", 64'(($countones(s_tready) <= 1) && (s_tready == '0 || m_tready)), 64'd1);
                if (m_tvalid && m_tready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL beat_unexpected: got beat %0h from grant %0d, required none", m_tdata, grant_idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_tdata, e.b.data);
                        chk("beat_keep", 64'(m_tkeep), 64'(e.b.keep));
                        chk("beat_last", 64'(m_tlast), 64'(e.b.last));
                        chk("beat_grant", 64'(grant_idx), 64'(e.req));
                        chk("beat_tready", 64'(s_tready), 64'(4'b0001 << e.req));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] busy_seq;
        logic [24:0] exp_seq;
        reset    = 1'b1;
        m_tready = 1'b0;
        CntClr   = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_cnt", 64'(FrmCnt), 64'd0);
        reset    = 1'b0;
        m_tready = 1'b1;
        tick();

        // Single 3-beat frame from requester 2.
        load_frame(2, 1, 3, 3);
        tick();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_mvalid", 64'(m_tvalid), 64'd0);
        chk("t1_idle_tready", 64'(s_tready), 64'd0);
        tick();
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_grant", 64'(grant_idx), 64'd2);
        chk("t1_beat0", m_tdata, mk(2, 1, 0, 3).data);
        chk("t1_last0", 64'(m_tlast), 64'd0);
        tick();
        chk("t1_beat1", m_tdata, mk(2, 1, 1, 3).data);
        tick();
        chk("t1_beat2", m_tdata, mk(2, 1, 2, 3).data);
        chk("t1_last2", 64'(m_tlast), 64'd1);
        tick();
        chk("t1_end_busy", 64'(busy), 64'd0);
        chk("t1_end_mvalid", 64'(m_tvalid), 64'd0);
        chk("t1_end_data", m_tdata, 64'd0);
        chk("t1_end_last", 64'(m_tlast), 64'd0);
        wait_done();

        // Round-robin fairness from a fresh reset: order 0,1,2,3,0,1,2,3 with one idle cycle each.
        reset = 1'b1;
        flush_sources();
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int r = 0; r < N; r++) load_frame(r, 10, 2, 2);
        for (int r = 0; r < N; r++) load_frame(r, 11, 2, 2);
        busy_seq = '0;
        exp_seq  = '0;
        for (int j = 0; j < 25; j++) begin
            tick();
            busy_seq[j] = busy;
            exp_seq[j]  = (j % 3 != 0);
        end
        chk("rr_busy_pattern", 64'(busy_seq), 64'(exp_seq));
        wait_done();

        // Backpressure: m_tready low for 5 cycles on beat 1 of requester 0.
        load_frame(0, 20, 4, 4);
        load_frame(2, 20, 2, 2);
        tick();
        tick();
        tick();
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_data", m_tdata, mk(0, 20, 1, 4).data);
            chk("bp_mvalid", 64'(m_tvalid), 64'd1);
            chk("bp_tready", 64'(s_tready), 64'd0);
            chk("bp_grant", 64'(grant_idx), 64'd0);
        end
        m_tready = 1'b1;
        wait_done();

        // Requester gap: requester 3 drops valid for 3 cycles while requester 1 waits.
        load_frame(3, 30, 4, 4);
        load_frame(1, 30, 1, 1);
        tick();
        tick();
        tick();
        gap[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gap_mvalid", 64'(m_tvalid), 64'd0);
            chk("gap_grant", 64'(grant_idx), 64'd3);
            chk("gap_busy", 64'(busy), 64'd1);
        end
        gap[3] = 1'b0;
        wait_done();

        // Frame counters: clear, five frames from requester 1, then clear on the sixth tlast.
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        tick();
        chk("cnt_clr_all", 64'(FrmCnt), 64'd0);
        for (int f = 0; f < 5; f++) load_frame(1, 40 + f, 1, 1);
        wait_done();
        chk("cnt_r1_five", 64'(FrmCnt[32 +: 32]), CNT_ON ? 64'd5 : 64'd0);
        chk("cnt_r0_zero", 64'(FrmCnt[0 +: 32]), 64'd0);
        load_frame(1, 50, 1, 1);
        tick();
        tick();
        chk("cnt_sixth_busy", 64'(busy), 64'd1);
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        chk("cnt_clr_wins", 64'(FrmCnt[32 +: 32]), 64'd0);
        chk("cnt_sixth_done", 64'(busy), 64'd0);
        wait_done();

        // Mid-frame reset during beat 1 of a 4-beat frame from requester 2.
        load_frame(2, 60, 4, 1);
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mrst_mvalid", 64'(m_tvalid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_tready", 64'(s_tready), 64'd0);
        flush_sources();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_idle", 64'(busy), 64'd0);
        chk("mrst_grant", 64'(grant_idx), 64'd0);
        load_frame(0, 70, 2, 2);
        load_frame(3, 70, 2, 2);
        tick();
        tick();
        chk("mrst_first_grant", 64'(grant_idx), 64'd0);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
